fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 35 +++
 rtl/fifo_uart_tx.sv | 139 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: the FSM state
// encoding and the default frame geometry.
package fifo_uart_pkg;

   localparam int DEFAULT_DATA_WIDTH   = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts clk cycles within one serial bit and flags the
// last cycle of each bit so the FSM can advance on bit boundaries.
module uart_baud_gen
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic bit_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   assign bit_tick = enable && (count == LAST_COUNT);

   // Count 0..CLKS_PER_BIT-1 while enabled, wrapping to 0 at each bit boundary.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         if (bit_tick) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an upstream synchronous FIFO: pops one byte,
// sends start / LSB-first data / stop, and chains frames back to back when
// more data is waiting at the end of the stop bit.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_r_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_next;
   logic [BIT_W-1:0]      bit_cnt;
   logic [BIT_W-1:0]      bit_cnt_next;
   logic                  tx_next;
   logic                  baud_clear;
   logic                  baud_en;
   logic                  bit_tick;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk      (clk),
      .rst      (rst),
      .clear    (baud_clear),
      .enable   (baud_en),
      .bit_tick (bit_tick)
   );

   assign busy = (state != IDLE);

   // State, shift register, bit counter and the registered serial line;
   // tx is loaded with the level of the state being entered so it is glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         tx        <= 1'b1;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         bit_cnt   <= bit_cnt_next;
         tx        <= tx_next;
      end
   end

   // Next-state logic, FIFO pop request and the level tx will take next cycle.
   always_comb begin
      state_next   = state;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt;
      tx_next      = 1'b1;
      fifo_r_en    = 1'b0;
      tx_done      = 1'b0;
      baud_clear   = 1'b0;
      baud_en      = 1'b0;

      case (state)
         IDLE: begin
            fifo_r_en = !fifo_empty;
            if (!fifo_empty) begin
               state_next = FETCH;
            end
         end

         FETCH: begin
            shift_next   = fifo_rd_data;
            bit_cnt_next = '0;
            baud_clear   = 1'b1;
            state_next   = START;
            tx_next      = 1'b0;
         end

         START: begin
            baud_en = 1'b1;
            tx_next = 1'b0;
            if (bit_tick) begin
               state_next = DATA;
               tx_next    = shift_reg[0];
            end
         end

         DATA: begin
            baud_en = 1'b1;
            tx_next = shift_reg[0];
            if (bit_tick) begin
               if (bit_cnt == LAST_BIT) begin
                  state_next   = STOP;
                  bit_cnt_next = '0;
                  tx_next      = 1'b1;
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
                  shift_next   = shift_reg >> 1;
                  tx_next      = shift_next[0];
               end
            end
         end

         STOP: begin
            baud_en = 1'b1;
            tx_next = 1'b1;
            if (bit_tick) begin
               tx_done = 1'b1;
               if (!fifo_empty) begin
                  fifo_r_en  = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = IDLE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      if (rst) begin
         fifo_r_en = 1'b0;
         tx_done   = 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4, DATA_WIDTH=8.
// A queue-based FIFO feeds the DUT; a frame-offset reference model predicts
// every output each cycle and a line-level receiver decodes the bytes sent.
module tb_fifo_uart_tx;

   localparam int DW    = 8;
   localparam int CPB   = 4;
   localparam int FRAME = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_r_en;
   logic          tx;
   logic          busy;
   logic          tx_done;

   fifo_uart_tx #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_r_en    (fifo_r_en),
      .tx           (tx),
      .busy         (busy),
      .tx_done      (tx_done)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   int            compared   = 0;
   int            mismatched = 0;
   int            cycle      = 0;

   logic [DW-1:0] fifoQ[$];
   logic [DW-1:0] refQ[$];
   logic [DW-1:0] rxQ[$];
   int            popCycles[$];
   int            doneCycles[$];

   bit            toggleEn  = 1'b0;
   bit            toggleBit = 1'b0;

   int            mPhase   = 0;
   int            mOff     = 0;
   logic [DW-1:0] mByte    = '0;
   logic [DW-1:0] mPending = '0;

   bit            rxActive = 1'b0;
   int            rxCnt    = 0;
   logic [DW-1:0] rxByte   = '0;
   logic          prevTx   = 1'b1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h",
                  tag, cycle, observed, expected);
      end
   endtask

   task automatic updateEmpty();
      fifo_empty = (fifoQ.size() == 0) || (toggleEn && toggleBit);
   endtask

   task automatic applyStimulus(input logic [DW-1:0] b);
      fifoQ.push_back(b);
      refQ.push_back(b);
      updateEmpty();
   endtask

   // One clock cycle: check all outputs against the model at the falling
   // edge, advance model and receiver, then update the FIFO after the rise.
   task automatic stepCycle();
      logic          expTx;
      logic          expDone;
      logic          expREn;
      logic [DW-1:0] tmp;
      logic          dutPop;
      logic          wasEmpty;
      int            b;
      int            k;

      @(negedge clk);
      expTx = 1'b1;
      if (mPhase == 2) begin
         b = mOff / CPB;
         if (b == 0) begin
            expTx = 1'b0;
         end else if (b <= DW) begin
            tmp   = mByte >> (b - 1);
            expTx = tmp[0];
         end
      end
      expDone = (mPhase == 2) && (mOff == FRAME - 1) && !rst;
      expREn  = !rst && !fifo_empty && ((mPhase == 0) || expDone);

      checkOutput("tx",        32'(tx),        32'(expTx));
      checkOutput("busy",      32'(busy),      32'(mPhase != 0));
      checkOutput("tx_done",   32'(tx_done),   32'(expDone));
      checkOutput("fifo_r_en", 32'(fifo_r_en), 32'(expREn));

      if (fifo_r_en === 1'b1) popCycles.push_back(cycle);
      if (tx_done === 1'b1) doneCycles.push_back(cycle);

      if (rst) begin
         rxActive = 1'b0;
      end else if (rxActive) begin
         rxCnt++;
         if (rxCnt > CPB / 2 && ((rxCnt - CPB / 2) % CPB) == 0) begin
            k = (rxCnt - CPB / 2) / CPB;
            if (k <= DW) begin
               rxByte = {tx, rxByte[DW-1:1]};
            end else begin
               if (tx === 1'b1) rxQ.push_back(rxByte);
               rxActive = 1'b0;
            end
         end
      end else if (prevTx === 1'b1 && tx === 1'b0) begin
         rxActive = 1'b1;
         rxCnt    = 0;
      end
      prevTx = tx;

      if (rst) begin
         mPhase = 0;
      end else begin
         case (mPhase)
            0: if (!fifo_empty) mPhase = 1;
            1: begin
               mPhase = 2;
               mOff   = 0;
               mByte  = mPending;
            end
            default: begin
               if (mOff == FRAME - 1) mPhase = fifo_empty ? 0 : 1;
               else mOff++;
            end
         endcase
      end
      if (expREn && refQ.size() > 0) mPending = refQ.pop_front();

      dutPop   = fifo_r_en;
      wasEmpty = fifo_empty;
      @(posedge clk);
      cycle++;
      #1;
      if (dutPop === 1'b1 && !wasEmpty && fifoQ.size() > 0) fifo_rd_data = fifoQ.pop_front();
      toggleBit = ~toggleBit;
      updateEmpty();
   endtask

   task automatic clearRecords();
      popCycles.delete();
      doneCycles.delete();
      rxQ.delete();
   endtask

   task automatic checkRx(input string tag, input logic [DW-1:0] sent[$]);
      checkOutput({tag, "_rx_count"}, 32'(rxQ.size()), 32'(sent.size()));
      for (int i = 0; i < sent.size(); i++) begin
         checkOutput({tag, "_rx_byte"}, (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hxxxx_xxxx,
                     32'(sent[i]));
      end
   endtask

   logic [DW-1:0] sent[$];

   initial begin
      rst        = 1'b1;
      fifo_empty = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset state while rst is held.
      repeat (3) stepCycle();
      rst = 1'b0;

      // Empty FIFO for 100 cycles: line idle, no pops.
      clearRecords();
      repeat (100) stepCycle();
      checkOutput("idle_pops", 32'(popCycles.size()), 32'd0);

      // Single byte 0xA5: pop-to-done latency and decoded content.
      clearRecords();
      applyStimulus(8'hA5);
      repeat (60) stepCycle();
      checkOutput("a5_pops", 32'(popCycles.size()), 32'd1);
      checkOutput("a5_latency",
                  (popCycles.size() > 0 && doneCycles.size() > 0) ?
                  32'(doneCycles[0] - popCycles[0]) : 32'hffff_ffff, 32'd41);
      sent = '{8'hA5};
      checkRx("a5", sent);

      // Back-to-back 0x00 then 0xFF: second pop on first tx_done cycle.
      clearRecords();
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      repeat (100) stepCycle();
      checkOutput("b2b_pops", 32'(popCycles.size()), 32'd2);
      checkOutput("b2b_chain",
                  (popCycles.size() > 1 && doneCycles.size() > 0) ?
                  32'(popCycles[1] - doneCycles[0]) : 32'hffff_ffff, 32'd0);
      sent = '{8'h00, 8'hFF};
      checkRx("b2b", sent);

      // Reset in the middle of 0x3C's data bits, then 0x81 must go out cleanly.
      clearRecords();
      applyStimulus(8'h3C);
      repeat (20) stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      repeat (50) stepCycle();
      checkOutput("abort_done", 32'(doneCycles.size()), 32'd0);
      applyStimulus(8'h81);
      repeat (50) stepCycle();
      checkOutput("after_abort_done", 32'(doneCycles.size()), 32'd1);
      sent = '{8'h81};
      checkRx("after_abort", sent);

      // fifo_empty toggling every cycle: no extra pops, content intact.
      clearRecords();
      toggleEn = 1'b1;
      sent.delete();
      for (int i = 0; i < 2; i++) begin
         sent.push_back(DW'($urandom_range(0, 255)));
         applyStimulus(sent[i]);
      end
      repeat (110) stepCycle();
      toggleEn = 1'b0;
      updateEmpty();
      checkOutput("toggle_pops", 32'(popCycles.size()), 32'd2);
      checkRx("toggle", sent);

      // Eight-byte burst from the queue FIFO.
      clearRecords();
      sent.delete();
      for (int i = 0; i < 8; i++) begin
         sent.push_back(DW'($urandom));
         applyStimulus(sent[i]);
      end
      repeat (8 * (FRAME + 1) + 20) stepCycle();
      checkOutput("burst_pops", 32'(popCycles.size()), 32'd8);
      checkOutput("burst_empty", 32'(fifo_empty), 32'd1);
      checkRx("burst", sent);

      // Random rounds: random gaps and 1..3 byte groups.
      for (int r = 0; r < 5; r++) begin
         clearRecords();
         sent.delete();
         repeat ($urandom_range(0, 5)) stepCycle();
         for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
            sent.push_back(DW'($urandom));
            applyStimulus(sent[sent.size() - 1]);
            repeat ($urandom_range(0, 2)) stepCycle();
         end
         repeat (3 * (FRAME + 1) + 20) stepCycle();
         checkOutput("rand_pops", 32'(popCycles.size()), 32'(sent.size()));
         checkRx("rand", sent);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
